// File: rtl/up_counter_ctrl_pkg.sv
// Shared opcodes, controller state encoding and state helpers for up_counter_ctrl.
package up_counter_ctrl_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == RUN) || (s == HOLD);
    endfunction

endpackage

// File: rtl/sync_up_counter_core.sv
// WIDTH-bit up counter register: synchronous clear beats enable; holds otherwise.
module sync_up_counter_core #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/up_counter_ctrl.sv
// Command-sequenced up counter controller (LOAD/START/PAUSE-RESUME/STOP).
// Optional prescaler on RUN advances is enabled by defining UP_COUNTER_CTRL_PRESCALE_EN.
import up_counter_ctrl_pkg::*;

module up_counter_ctrl #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned PRE_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_DATA,
`ifdef UP_COUNTER_CTRL_PRESCALE_EN
    input  logic [PRE_W-1:0] PRE_DIV,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BUSY,
    output logic             ERR
);

    state_e           state_q;
    logic [WIDTH-1:0] limit_q;
    logic             auto_q;
    logic             ready_q;
    logic             tc_q;
    logic             err_q;

    logic             accept;
    logic             op_load, op_start, op_pause, op_stop;
    logic             start_go, stop_go, illegal;
    logic             pre_tick, run_tick, at_lim;
    logic             cnt_clr, cnt_en;
    logic [WIDTH-1:0] cnt;

    // The RUN advance happens on every tick regardless of the accepted command;
    // the command then overrides next state, and STOP/START override Q.
    always_comb begin
        accept   = CMD_VALID && ready_q;
        op_load  = accept && (CMD_OP == OP_LOAD);
        op_start = accept && (CMD_OP == OP_START);
        op_pause = accept && (CMD_OP == OP_PAUSE);
        op_stop  = accept && (CMD_OP == OP_STOP);
        start_go = op_start && ((state_q == IDLE) || (state_q == DONE));
        stop_go  = op_stop && (state_q != IDLE);
        illegal  = (op_pause && ((state_q == IDLE) || (state_q == DONE)))
                || ((op_load || op_start) && is_busy(state_q));
        run_tick = (state_q == RUN) && pre_tick;
        at_lim   = run_tick && (cnt == limit_q);
        cnt_clr  = start_go || stop_go || (at_lim && auto_q);
        cnt_en   = run_tick && !at_lim;
    end

`ifdef UP_COUNTER_CTRL_PRESCALE_EN
    logic [PRE_W-1:0] pre_q;

    // >= so that lowering PRE_DIV below the running count still yields a tick.
    assign pre_tick = (pre_q >= PRE_DIV);

    always_ff @(posedge CLK) begin
        if (RST || start_go || op_stop || ((state_q == RUN) && op_pause)) begin
            pre_q <= '0;
        end else if (state_q == RUN) begin
            pre_q <= pre_tick ? '0 : pre_q + PRE_W'(1);
        end
    end
`else
    assign pre_tick = (PRE_W != 0);
`endif

    sync_up_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .q_o   (cnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            limit_q <= '1;
            auto_q  <= 1'b1;
            ready_q <= 1'b0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= !accept;
            tc_q    <= at_lim;
            err_q   <= illegal;
            unique case (state_q)
                IDLE: begin
                    if (op_load) begin
                        limit_q <= CMD_DATA;
                    end else if (op_start) begin
                        auto_q  <= CMD_DATA[0];
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (op_stop) begin
                        state_q <= IDLE;
                    end else if (op_pause) begin
                        state_q <= HOLD;
                    end else if (at_lim && !auto_q) begin
                        state_q <= DONE;
                    end
                end
                HOLD: begin
                    if (op_pause) begin
                        state_q <= RUN;
                    end else if (op_stop) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    if (op_start) begin
                        auto_q  <= CMD_DATA[0];
                        state_q <= RUN;
                    end else if (op_load) begin
                        limit_q <= CMD_DATA;
                    end else if (op_stop) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign CMD_READY = ready_q;
    assign TC        = tc_q;
    assign ERR       = err_q;
    assign BUSY      = is_busy(state_q);
    assign Q         = cnt;

endmodule

// File: doc/up_counter_ctrl.md
Name: up_counter_ctrl

Overview:
Controller that sequences a WIDTH-bit synchronous up counter under command control.
- Accepts LOAD / START / PAUSE-RESUME / STOP commands over a valid/ready handshake.
- Programs a terminal limit and runs the count in one-shot or auto-reload mode.
- Emits a one-cycle terminal-count pulse.
- Sits between a host/sequencer and the counter datapath, replacing free-running counting with scheduled counting.

Parameters:
- WIDTH, 3, counter and limit width in bits.
- PRE_W, 4, prescaler divide-value width (used only with the optional feature).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  controller can accept a command this cycle.
- CMD_OP  input  2  opcode: 00 LOAD, 01 START, 10 PAUSE/RESUME, 11 STOP.
- CMD_DATA  input  WIDTH  LOAD: new limit. START: bit0 = AUTO (1 = auto-reload, 0 = one-shot).
- Q  output  WIDTH  current count.
- TC  output  1  terminal-count pulse.
- BUSY  output  1  high in RUN or HOLD.
- ERR  output  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset values: Q=0, TC=0, BUSY=0, ERR=0, CMD_READY=0 while RST=1, LIMIT=all-ones (7), AUTO=1, state IDLE.
- CMD_READY rises in the first cycle after RST falls.
- Handshake:
  - A command is accepted when CMD_VALID & CMD_READY at a rising edge.
  - CMD_READY drops for exactly one cycle after each acceptance, so at most one command every 2 cycles.
  - CMD_READY never depends on CMD_OP or CMD_DATA.
- States: IDLE, RUN, HOLD, DONE.
- IDLE: Q held.
  - LOAD: LIMIT<=CMD_DATA.
  - START: AUTO<=CMD_DATA[0], Q<=0, go RUN.
  - PAUSE: ERR pulse, no state change.
  - STOP: no-op.
- RUN: Q advances by 1 each cycle (each prescaler tick if enabled).
  - If Q==LIMIT at an advance, TC=1 in the following cycle.
  - AUTO=1: Q<=0, stay in RUN.
  - AUTO=0: Q held at LIMIT, go DONE.
  - PAUSE: go HOLD, Q frozen.
  - STOP: Q<=0, go IDLE.
  - LOAD or START: ERR pulse, ignored.
- HOLD: Q frozen.
  - PAUSE: back to RUN; counting resumes on the next cycle.
  - STOP: Q<=0, go IDLE.
  - LOAD or START: ERR pulse.
- DONE: Q=LIMIT, BUSY=0.
  - START: Q<=0, go RUN.
  - LOAD: LIMIT updated, stay in DONE.
  - STOP: Q<=0, go IDLE.
  - PAUSE: ERR pulse.
- LIMIT=0:
  - Auto mode: TC every advance, Q stays 0.
  - One-shot: DONE after one advance.
- Arithmetic: the increment is modulo 2^WIDTH. Q never exceeds LIMIT, so natural wrap occurs only at LIMIT=all-ones.
- Simultaneous command and terminal condition in RUN:
  - TC still pulses.
  - The accepted command decides next state and Q (STOP beats reload/DONE; PAUSE leaves Q at its wrapped/held value).
- RST mid-operation overrides everything in the same edge. Any pending TC or ERR is cleared.

Optional Feature:
- Macro UP_COUNTER_CTRL_PRESCALE_EN.
- When defined:
  - Adds port PRE_DIV input PRE_W.
  - A prescaler advances Q once every PRE_DIV+1 cycles in RUN.
  - The prescaler resets to 0 on RST, START, STOP and entry to HOLD.
  - PRE_DIV is sampled each tick.
- When undefined: Q advances every RUN cycle and no PRE_DIV port exists.

Decomposition:
- Package up_counter_ctrl_pkg holds:
  - opcode constants OP_LOAD / OP_START / OP_PAUSE / OP_STOP;
  - state encoding IDLE=0, RUN=1, HOLD=2, DONE=3.
- One sub-module, sync_up_counter_core: WIDTH-bit register with synchronous clear, enable and hold, controlled by the FSM.

Test Plan:
- Reset then START with AUTO=1 and default LIMIT=7 -> Q counts 0..7,0; TC pulses the cycle after each 7; BUSY=1.
- LOAD 5, START with AUTO=0 -> Q 0..5 then held at 5; one TC pulse; state DONE; BUSY=0; a second START restarts from 0.
- During RUN at Q=3: PAUSE, wait 4 cycles, PAUSE -> Q stays 3 for 4 cycles, then resumes 4,5...
- LOAD during RUN, and PAUSE in IDLE -> ERR one-cycle pulse each; LIMIT unchanged.
- STOP accepted in the same cycle Q==LIMIT (auto) -> TC pulses, Q=0, IDLE, BUSY=0.
- Back-to-back CMD_VALID held high -> CMD_READY alternates 1,0; RST asserted mid-RUN at Q=4 -> next cycle Q=0, IDLE, LIMIT=7.
